// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage.
// Holds the exe_cmd operation codes, the operand-2 shift-type codes,
// the iterative multiplier state enum and the bit positions of the
// N, Z, C and V flags inside the 4-bit status word {N,Z,C,V}.
package exe_pkg;

  // Operation codes carried on exe_cmd.
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;  // also LDR/STR address add
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;  // also CMP
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;  // also TST
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MUL = 4'b1010;

  // Register-operand shift types, shift_operand[6:5].
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Iterative multiplier sequencing.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_t;

  // Flag positions inside status = {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_p_val2_gen.sv
// val2_gen: combinational second-operand generator.
// Ports:
//   mem_en        in   load/store access; selects the zero-extended offset
//   imm           in   immediate form: imm8 rotated right by 2*rotate
//   shift_operand in   12-bit operand-2 field
//   val_rm        in   register operand to shift in register form
//   val2          out  generated second operand
// Priority: memory offset, then immediate, then shifted register.
module val2_gen
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              mem_en,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] val2
);

  // Rotate right; the amount is reduced modulo DATA_W so narrow
  // datapaths still rotate rather than shift everything out.
  function automatic logic [DATA_W-1:0] ror_w(input logic [DATA_W-1:0] x,
                                              input logic [5:0]        amt);
    logic [2*DATA_W-1:0] dbl;
    int unsigned         a;
    a   = int'(amt) % DATA_W;
    dbl = {x, x} >> a;
    return dbl[DATA_W-1:0];
  endfunction

  logic [4:0] shift_imm;
  logic [1:0] shift_type;

  assign shift_imm  = shift_operand[11:7];
  assign shift_type = shift_operand[6:5];

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    val2 = '0;
    if (mem_en) begin
      val2 = DATA_W'(shift_operand);
    end else if (imm) begin
      val2 = ror_w(DATA_W'(shift_operand[7:0]), {shift_operand[11:8], 1'b0});
    end else begin
      case (shift_type)
        SH_LSL:  val2 = val_rm << shift_imm;
        SH_LSR:  val2 = val_rm >> shift_imm;
        SH_ASR:  val2 = $signed(val_rm) >>> shift_imm;
        SH_ROR:  val2 = ror_w(val_rm, {1'b0, shift_imm});
        default: val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_p.sv
// exe_stage_p: execute stage and EX/MEM pipeline register.
// Generates operand 2 (val2_gen), runs the ALU, computes the branch target,
// owns the NZCV status register and an iterative shift-add multiplier that
// stalls upstream until the product is ready.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    drop the instruction at the inputs (and any MUL)
//   in_valid, exe_cmd        live-instruction flag and operation code
//   s_en, wb_en, mem_r_en,
//   mem_w_en, b_en, dest     control bits and destination from ID
//   pc, val_rn, val_rm       PC+4 and register operands
//   imm, shift_operand       operand-2 form and field
//   signed_imm_24            branch word offset
//   stall                    combinational hold request to upstream
//   out_*                    registered EX/MEM slot contents
//   status                   registered {N,Z,C,V}
module exe_stage_p
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic              s_en,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              b_en,
  input  logic [3:0]        dest,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [IMM_W-1:0]  signed_imm_24,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DATA_W-1:0] out_br_addr,
  output logic [3:0]        out_dest,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic              out_br_taken,
  output logic [3:0]        status
);

  localparam int CNT_W = $clog2(DATA_W);

  // Operand 2
  logic [DATA_W-1:0] val2;

  val2_gen #(.DATA_W(DATA_W)) u_val2_gen (
    .mem_en        (mem_r_en | mem_w_en),
    .imm           (imm),
    .shift_operand (shift_operand),
    .val_rm        (val_rm),
    .val2          (val2)
  );

  // Multiplier state
  mul_state_t        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mcand;   // multiplicand, shifted left each step
  logic [DATA_W-1:0] mplier;  // multiplier, shifted right each step
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mul_product;
  logic              is_mul;
  logic              mul_last;
  logic              complete;

  assign is_mul      = (exe_cmd == EXE_MUL);
  assign mul_last    = (state == ST_MUL) && (count == CNT_W'(DATA_W - 1));
  // Accumulator including the current step; on the last step this is the product.
  assign mul_product = acc + (mplier[0] ? mcand : '0);

  // Reset is folded in so stall drops the moment reset is applied,
  // even while upstream still presents the MUL.
  assign stall    = ~rst & in_valid & is_mul & ~mul_last & ~flush;
  assign complete = in_valid & ~stall & ~flush;

  // Adder shared by ADD/ADC/SUB/SBC: subtraction is rn + ~val2 + carry-in.
  logic [DATA_W-1:0] add_b;
  logic              add_ci;
  logic [DATA_W:0]   sum;
  logic              add_v;

  always_comb begin
    add_b  = val2;
    add_ci = 1'b0;
    case (exe_cmd)
      EXE_ADC: add_ci = status[FLAG_C];
      EXE_SUB: begin add_b = ~val2; add_ci = 1'b1;           end
      EXE_SBC: begin add_b = ~val2; add_ci = status[FLAG_C]; end
      default: ;
    endcase
  end

  assign sum   = {1'b0, val_rn} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_ci};
  assign add_v = (val_rn[DATA_W-1] == add_b[DATA_W-1]) &&
                 (sum[DATA_W-1] != val_rn[DATA_W-1]);

  // ALU
  logic [DATA_W-1:0] alu_result;
  logic              cv_upd;     // op belongs to the add/sub class
  logic              known_op;   // defined opcode; unknown ones leave flags alone
  logic [3:0]        flags_next;

  always_comb begin
    alu_result = '0;
    cv_upd     = 1'b0;
    known_op   = 1'b1;
    case (exe_cmd)
      EXE_MOV: alu_result = val2;
      EXE_MVN: alu_result = ~val2;
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
        alu_result = sum[DATA_W-1:0];
        cv_upd     = 1'b1;
      end
      EXE_AND: alu_result = val_rn & val2;
      EXE_ORR: alu_result = val_rn | val2;
      EXE_EOR: alu_result = val_rn ^ val2;
      EXE_MUL: alu_result = mul_product;
      default: known_op   = 1'b0;
    endcase
  end

  always_comb begin
    flags_next         = status;
    flags_next[FLAG_N] = alu_result[DATA_W-1];
    flags_next[FLAG_Z] = (alu_result == '0);
    if (cv_upd) begin
      flags_next[FLAG_C] = sum[DATA_W];
      flags_next[FLAG_V] = add_v;
    end
  end

  // Branch target: word offset sign-extended, scaled by 4, added to PC+4.
  logic [DATA_W-1:0] br_off;
  assign br_off = DATA_W'($signed(signed_imm_24));

  // Multiplier sequencer
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && is_mul) begin
            mcand  <= val_rn;
            mplier <= val_rm;
            acc    <= '0;
            count  <= '0;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (!(in_valid && is_mul) || mul_last) begin
            // Product taken by the output register (or instruction vanished).
            state <= ST_IDLE;
            count <= '0;
          end else begin
            acc    <= mul_product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // EX/MEM register and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_alu_result <= '0;
      out_val_rm     <= '0;
      out_br_addr    <= '0;
      out_dest       <= '0;
      out_wb_en      <= 1'b0;
      out_mem_r_en   <= 1'b0;
      out_mem_w_en   <= 1'b0;
      out_br_taken   <= 1'b0;
      status         <= '0;
    end else begin
      out_valid <= complete;
      if (complete) begin
        out_alu_result <= alu_result;
        out_val_rm     <= val_rm;
        out_br_addr    <= pc + (br_off << 2);
        out_dest       <= dest;
        out_wb_en      <= wb_en;
        out_mem_r_en   <= mem_r_en;
        out_mem_w_en   <= mem_w_en;
        out_br_taken   <= b_en;
        if (s_en && known_op) status <= flags_next;
      end else begin
        // Bubble: side-effect controls must not act on stale data.
        out_wb_en    <= 1'b0;
        out_mem_r_en <= 1'b0;
        out_mem_w_en <= 1'b0;
        out_br_taken <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_p.sv
// tb_exe_stage_p: directed self-checking bench for exe_stage_p.
module tb_exe_stage_p;

  localparam logic [3:0] C_MOV = 4'b0001, C_MVN = 4'b1001, C_ADD = 4'b0010,
                         C_ADC = 4'b0011, C_SUB = 4'b0100, C_SBC = 4'b0101,
                         C_AND = 4'b0110, C_ORR = 4'b0111, C_EOR = 4'b1000,
                         C_MUL = 4'b1010, C_BAD = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, s_en, wb_en, mem_r_en, mem_w_en, b_en, imm;
  logic [3:0]  exe_cmd, dest;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic        stall, out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_br_taken;
  logic [31:0] out_alu_result, out_val_rm, out_br_addr;
  logic [3:0]  out_dest, status;

  int total = 0;
  int bad   = 0;

  exe_stage_p dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .exe_cmd(exe_cmd),
    .s_en(s_en), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .b_en(b_en), .dest(dest), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
    .imm(imm), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .stall(stall), .out_valid(out_valid), .out_alu_result(out_alu_result),
    .out_val_rm(out_val_rm), .out_br_addr(out_br_addr), .out_dest(out_dest),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
    .out_mem_w_en(out_mem_w_en), .out_br_taken(out_br_taken), .status(status)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 0; in_valid = 0; exe_cmd = 0; s_en = 0; wb_en = 0;
    mem_r_en = 0; mem_w_en = 0; b_en = 0; dest = 0; pc = 0;
    val_rn = 0; val_rm = 0; imm = 0; shift_operand = 0; signed_imm_24 = 0;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                       input logic im, input logic [11:0] shop, input logic s);
    exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = im; shift_operand = shop;
    s_en = s; mem_r_en = 0; mem_w_en = 0; in_valid = 1;
  endtask

  // Counts consecutive stall-high cycles (bounded) and notes any out_valid
  // seen after the first stalled cycle.
  task automatic run_mul_stall(output int n, output bit early_valid);
    n = 0;
    early_valid = 0;
    #1;
    while (stall && n < 40) begin
      if (n != 0 && out_valid) early_valid = 1;
      n++;
      step();
    end
  endtask

  task automatic test_reset;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_alu_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", out_alu_result); end
    total++; if (status !== 4'b0000) begin bad++; $display("FAIL reset_status got=%b want=0000", status); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
  endtask

  task automatic test_add_imm;
    issue(C_ADD, 32'd5, 32'hDEADBEEF, 1'b1, 12'h203, 1'b0);
    wb_en = 1; dest = 4'd3;
    step();
    total++; if (out_alu_result !== 32'h30000005) begin bad++; $display("FAIL add_imm_result got=%h want=30000005", out_alu_result); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_imm_valid got=%b want=1", out_valid); end
    total++; if (out_dest !== 4'd3 || out_wb_en !== 1'b1) begin bad++; $display("FAIL add_imm_ctrl got=%h/%b want=3/1", out_dest, out_wb_en); end
    total++; if (out_val_rm !== 32'hDEADBEEF) begin bad++; $display("FAIL add_imm_val_rm got=%h want=deadbeef", out_val_rm); end
    idle_inputs();
    step();
    total++; if (out_valid !== 1'b0 || out_wb_en !== 1'b0) begin bad++; $display("FAIL bubble got=%b/%b want=0/0", out_valid, out_wb_en); end
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] rn, rm;
    logic        im;
    logic [11:0] shop;
    logic        mr;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  task automatic test_ops_table;
    vec_t v[7];
    v[0] = '{C_MOV, 32'h0,        32'h000000F1, 1'b0, 12'h260, 1'b0, 1'b0, 32'h1000000F}; // ROR #4
    v[1] = '{C_MVN, 32'h0,        32'hF0000000, 1'b0, 12'h420, 1'b0, 1'b0, 32'hFF0FFFFF}; // LSR #8
    v[2] = '{C_AND, 32'hFFFF0000, 32'h80000000, 1'b0, 12'h240, 1'b0, 1'b0, 32'hF8000000}; // ASR #4
    v[3] = '{C_ORR, 32'h0000000F, 32'h00000001, 1'b0, 12'h200, 1'b0, 1'b0, 32'h0000001F}; // LSL #4
    v[4] = '{C_EOR, 32'h000000FF, 32'h0,        1'b1, 12'h0FF, 1'b0, 1'b0, 32'h00000000};
    v[5] = '{C_ADD, 32'h00001000, 32'h0,        1'b1, 12'hABC, 1'b1, 1'b0, 32'h00001ABC}; // mem offset wins over imm
    v[6] = '{C_BAD, 32'h5,        32'h5,        1'b0, 12'h000, 1'b0, 1'b1, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      issue(v[i].cmd, v[i].rn, v[i].rm, v[i].im, v[i].shop, v[i].s);
      mem_r_en = v[i].mr;
      step();
      total++;
      if (out_alu_result !== v[i].exp) begin
        bad++; $display("FAIL op_row%0d got=%h want=%h", i, out_alu_result, v[i].exp);
      end
    end
    total++; if (status !== 4'b0000) begin bad++; $display("FAIL unknown_op_flags got=%b want=0000", status); end
    idle_inputs();
  endtask

  task automatic test_sub_adc;
    issue(C_SUB, 32'd3, 32'd3, 1'b0, 12'h000, 1'b1);
    step();
    total++; if (out_alu_result !== 32'h0) begin bad++; $display("FAIL sub_result got=%h want=0", out_alu_result); end
    total++; if (status !== 4'b0110) begin bad++; $display("FAIL sub_status got=%b want=0110", status); end
    issue(C_ADC, 32'd1, 32'd1, 1'b0, 12'h000, 1'b0);
    step();
    total++; if (out_alu_result !== 32'd3) begin bad++; $display("FAIL adc_result got=%h want=3", out_alu_result); end
    issue(C_SUB, 32'd2, 32'd5, 1'b0, 12'h000, 1'b1);
    step();
    total++; if (status !== 4'b1000) begin bad++; $display("FAIL sub_borrow_status got=%b want=1000", status); end
    issue(C_SBC, 32'd5, 32'd2, 1'b0, 12'h000, 1'b0);
    step();
    total++; if (out_alu_result !== 32'd2) begin bad++; $display("FAIL sbc_result got=%h want=2", out_alu_result); end
    idle_inputs();
  endtask

  task automatic test_mul;
    int n;
    bit early;
    issue(C_ADD, 32'h80000000, 32'h80000000, 1'b0, 12'h000, 1'b1);
    step();
    total++; if (status !== 4'b0111) begin bad++; $display("FAIL add_cv_status got=%b want=0111", status); end
    issue(C_MUL, 32'd7, 32'd6, 1'b0, 12'h000, 1'b1);
    run_mul_stall(n, early);
    total++; if (n != 32) begin bad++; $display("FAIL mul_stall_cycles got=%0d want=32", n); end
    total++; if (early) begin bad++; $display("FAIL mul_early_valid got=1 want=0"); end
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_valid got=%b want=1", out_valid); end
    total++; if (out_alu_result !== 32'd42) begin bad++; $display("FAIL mul_result got=%h want=2a", out_alu_result); end
    total++; if (status !== 4'b0011) begin bad++; $display("FAIL mul_status got=%b want=0011", status); end
    idle_inputs();
  endtask

  task automatic test_flush_mul;
    issue(C_MUL, 32'd3, 32'd5, 1'b0, 12'h000, 1'b1);
    repeat (10) step();
    flush = 1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall); end
    step();
    idle_inputs();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    total++; if (status !== 4'b0011) begin bad++; $display("FAIL flush_status got=%b want=0011", status); end
    issue(C_ADD, 32'd2, 32'd9, 1'b0, 12'h000, 1'b0);
    step();
    total++; if (out_valid !== 1'b1 || out_alu_result !== 32'd11) begin
      bad++; $display("FAIL post_flush_add got=%b/%h want=1/b", out_valid, out_alu_result);
    end
    idle_inputs();
  endtask

  task automatic test_mov_flags;
    issue(C_MOV, 32'h0, 32'h80000000, 1'b0, 12'h000, 1'b1);
    step();
    total++; if (status !== 4'b1011) begin bad++; $display("FAIL mov_flags got=%b want=1011", status); end
    idle_inputs();
  endtask

  task automatic test_branch;
    issue(C_MOV, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
    pc = 32'h100; signed_imm_24 = 24'hFFFFFE; b_en = 1;
    step();
    total++; if (out_br_addr !== 32'h000000F8) begin bad++; $display("FAIL br_addr got=%h want=f8", out_br_addr); end
    total++; if (out_br_taken !== 1'b1) begin bad++; $display("FAIL br_taken got=%b want=1", out_br_taken); end
    idle_inputs();
    step();
    total++; if (out_br_taken !== 1'b0) begin bad++; $display("FAIL br_bubble got=%b want=0", out_br_taken); end
  endtask

  task automatic test_reset_mid_mul;
    int n;
    bit early;
    issue(C_MUL, 32'd2, 32'd3, 1'b0, 12'h000, 1'b0);
    repeat (5) step();
    rst = 1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mul_stall got=%b want=0", stall); end
    total++; if (status !== 4'b0000 || out_br_addr !== 32'h0 || out_alu_result !== 32'h0) begin
      bad++; $display("FAIL rst_mul_outputs got=%b/%h/%h want=0/0/0", status, out_br_addr, out_alu_result);
    end
    rst = 0;
    run_mul_stall(n, early);
    total++; if (n != 32) begin bad++; $display("FAIL rst_mul_restart_cycles got=%0d want=32", n); end
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_alu_result !== 32'd6) begin
      bad++; $display("FAIL rst_mul_product got=%b/%h want=1/6", out_valid, out_alu_result);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #12;
    test_reset();
    rst = 0;
    step();
    test_add_imm();
    test_ops_table();
    test_sub_adc();
    test_mul();
    test_flush_mul();
    test_mov_flags();
    test_branch();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
